sd_cmd_transmitter: RTL and testbench
=====================================

# sd_cmd_transmitter

Serialises one SD-card SPI command frame (start bits, 6-bit command index, 32-bit argument, serially computed CRC7, end bit) onto MOSI, paced by the synchronised SCLK edge strobes from the SD clock generator. It is the transmit-side partner of the SD reader's SPI response receiver. The SD card controller FSM issues a command here, then hands off to the receiver to collect the R1/R7 response.

## Interface
Parameters:
- PRE_BYTES, 1: number of all-ones filler bytes (MOSI high) sent before the frame; 0 is legal.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- sclk_posedge  in  1  one-clk strobe marking an SCLK rising edge (card samples).
- sclk_negedge  in  1  one-clk strobe marking an SCLK falling edge (MOSI may change).
- start  in  1  request; sampled only in IDLE.
- cmd_index  in  6  command number, latched on accepted start.
- argument  in  32  command argument, latched on accepted start.
- mosi  out  1  serial data to card, MSB first.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-clk pulse on frame completion.

## Operation
- Frame (48 bits, MSB first): 0, 1, cmd_index[5:0], argument[31:0], crc7[6:0], 1.
- CRC7: polynomial x^7+x^3+1, init 0, computed serially over the first 40 bits as each bit is driven: fb = bit ^ crc[6]; crc <= {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00). No lookup table.
- States:
  - IDLE: mosi=1, busy=0. On start: latch 40-bit header into shift register, clear crc and bit counter, go PRE (PRE_BYTES>0) or FRAME.
  - PRE: mosi=1; count PRE_BYTES*8 sclk_negedge strobes, then FRAME.
  - FRAME: on each sclk_negedge drive next header bit and update crc; after bit 40 is driven, go CRC.
  - CRC: on each sclk_negedge drive crc[6] and shift crc left; after 7 bits go END.
  - END: on sclk_negedge drive 1 (end bit); go FINISH.
  - FINISH: on next sclk_posedge (card samples end bit) pulse done for one clk, go IDLE.
- Header bits shift out of a 40-bit register; 6-bit bit counter, 0..47 without wrap; PRE counter sized $clog2(PRE_BYTES*8+1), minimum 1 bit.
- start while busy: ignored, no effect on latched fields or timing.
- cmd_index/argument changes after acceptance: no effect on current frame.
- sclk_posedge/sclk_negedge never assert in the same clk; if both do, negedge action taken, posedge ignored.

## Timing
- Reset values: mosi=1, busy=0, done=0, state IDLE, counters 0, crc 0.
- Reset mid-operation: abort immediately next clk to reset values; no done pulse; no partial state survives.
- Accepted start: busy=1 the next clk; mosi stays 1 until the first qualifying sclk_negedge.
- Each bit changes only on the clk following a sclk_negedge strobe (registered output), held for one full SCLK period.
- Total: PRE_BYTES*8 + 48 sclk_negedge strobes after start, then done on the following sclk_posedge's next clk; busy drops the same clk done pulses.
- New start accepted on the clk after done (IDLE), back-to-back frames legal.
- mosi returns to/holds 1 in IDLE.

## Test plan
- CMD0, argument 0x00000000, PRE_BYTES=1 -> card-side samples on sclk_posedge: 0xFF, 0x40, 0x00, 0x00, 0x00, 0x00, 0x95; single done pulse; busy high throughout.
- CMD8, argument 0x000001AA -> bytes 0x48, 0x00, 0x00, 0x01, 0xAA, 0x87 after filler.
- PRE_BYTES=0 and PRE_BYTES=2 builds, CMD0 -> first sampled bit 0 with no filler / exactly 16 ones before 0x40.
- Second start pulsed mid-frame with cmd_index=17 -> frame is unchanged CMD0 bytes, exactly one done.
- reset asserted after 20 frame bits -> next clk mosi=1, busy=0, no done; following CMD0 start yields correct 0x95 CRC (crc cleared).
- Back-to-back: start held high continuously -> two consecutive complete CMD0 frames, start of second accepted clk after first done, two done pulses.

Source files
------------

// File: rtl/sd_cmd_transmitter.sv
// sd_cmd_transmitter: serialises an SD SPI command frame (filler, header, CRC7, end bit) onto mosi,
// stepping one bit per SCLK falling-edge strobe.
`timescale 1ns/1ps
module sd_cmd_transmitter #(
    parameter int PRE_BYTES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk_posedge,
    input  logic        sclk_negedge,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] argument,
    output logic        mosi,
    output logic        busy,
    output logic        done
);
    localparam int PRE_BITS = PRE_BYTES * 8;
    localparam int PW = (PRE_BYTES == 0) ? 1 : $clog2(PRE_BITS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'((PRE_BITS == 0) ? 0 : PRE_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_CRC, S_END, S_FINISH} state_t;

    state_t         state, state_nxt;
    logic [39:0]    hdr;
    logic [6:0]     crc;
    logic [6:0]     crc_upd;
    logic [5:0]     bit_cnt;
    logic [PW-1:0]  pre_cnt;
    logic           neg, pos;

    // a coincident posedge strobe is dropped in favour of the negedge
    assign neg = sclk_negedge;
    assign pos = sclk_posedge & ~sclk_negedge;
    assign crc_upd = {crc[5:0], 1'b0} ^ ((hdr[39] ^ crc[6]) ? 7'h09 : 7'h00);

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = (PRE_BYTES > 0) ? S_PRE : S_FRAME;
            S_PRE:    if (neg && pre_cnt == PRE_LAST) state_nxt = S_FRAME;
            S_FRAME:  if (neg && bit_cnt == 6'd39) state_nxt = S_CRC;
            S_CRC:    if (neg && bit_cnt == 6'd46) state_nxt = S_END;
            S_END:    if (neg) state_nxt = S_FINISH;
            S_FINISH: if (pos) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = state != S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr     <= '0;
            crc     <= '0;
            bit_cnt <= '0;
            pre_cnt <= '0;
            mosi    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= state == S_FINISH && pos;
            case (state)
                S_IDLE: begin
                    mosi <= 1'b1;
                    if (start) begin
                        hdr     <= {2'b01, cmd_index, argument};
                        crc     <= '0;
                        bit_cnt <= '0;
                        pre_cnt <= '0;
                    end
                end
                S_PRE: if (neg) pre_cnt <= pre_cnt + 1'b1;
                S_FRAME: if (neg) begin
                    mosi    <= hdr[39];
                    hdr     <= {hdr[38:0], 1'b0};
                    crc     <= crc_upd;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_CRC: if (neg) begin
                    mosi    <= crc[6];
                    crc     <= {crc[5:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                S_END: if (neg) mosi <= 1'b1;
                default: mosi <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_transmitter.sv
// tb_sd_cmd_transmitter: drives PRE_BYTES=0/1/2 transmitters in parallel and scoreboards the bytes
// a card would sample on each SCLK rising edge, plus busy/done handshake and reset behaviour.
`timescale 1ns/1ps
module tb_sd_cmd_transmitter;
    logic        clk = 1'b0;
    logic        reset, sclk_posedge, sclk_negedge;
    logic [2:0]  start_v;
    logic [5:0]  cmd_index;
    logic [31:0] argument;
    logic [2:0]  mosi_v, busy_v, done_v;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_cmd_transmitter #(.PRE_BYTES(g)) dut (
            .clk(clk), .reset(reset), .sclk_posedge(sclk_posedge), .sclk_negedge(sclk_negedge),
            .start(start_v[g]), .cmd_index(cmd_index), .argument(argument),
            .mosi(mosi_v[g]), .busy(busy_v[g]), .done(done_v[g])
        );
    end

    int          vectors = 0, miscompares = 0;
    logic [47:0] exp_q[3][$];
    logic [47:0] cur[3];
    bit          active[3], acc[3], done_exp[3];
    int          nneg[3], ncap[3];
    logic [7:0]  sh[3];

    // reference frame: CRC7 as the remainder of polynomial division by x^7+x^3+1
    function automatic logic [47:0] frame_of(input logic [5:0] c, input logic [31:0] a);
        logic [46:0] r;
        r = {2'b01, c, a, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] ^= 8'h89;
        return {2'b01, c, a, r[6:0], 1'b1};
    endfunction

    initial begin
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
        forever begin
            @(posedge clk); #1 sclk_negedge = 1'b1;
            @(posedge clk); #1 sclk_negedge = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(posedge clk); #1 sclk_posedge = 1'b1;
            @(posedge clk); #1 sclk_posedge = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
    end

    // monitor: models acceptance, captures card-side bits, checks bytes and handshake
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                active[k] = 0; acc[k] = 0; done_exp[k] = 0;
            end else begin
                logic eb, ed;
                if (acc[k]) begin
                    active[k] = 1; acc[k] = 0; nneg[k] = 0; ncap[k] = 0;
                end
                eb = active[k] && !done_exp[k];
                ed = done_exp[k];
                vectors++;
                if (busy_v[k] !== eb || done_v[k] !== ed || (!eb && mosi_v[k] !== 1'b1)) begin
                    miscompares++;
                    $display("FAIL handshake dut%0d t=%0t: busy=%b done=%b mosi=%b, want busy=%b done=%b mosi=1(if idle)",
                             k, $time, busy_v[k], done_v[k], mosi_v[k], eb, ed);
                end
                if (done_exp[k]) begin
                    done_exp[k] = 0; active[k] = 0;
                end
                if (active[k]) begin
                    if (sclk_negedge) nneg[k]++;
                    if (sclk_posedge && ncap[k] < nneg[k] && ncap[k] < k * 8 + 48) begin
                        sh[k] = {sh[k][6:0], mosi_v[k]};
                        ncap[k]++;
                        if (ncap[k] % 8 == 0) begin
                            int b;
                            logic [7:0] eby;
                            b = ncap[k] / 8 - 1;
                            eby = (b < k) ? 8'hFF : cur[k][47 - 8 * (b - k) -: 8];
                            vectors++;
                            if (sh[k] !== eby) begin
                                miscompares++;
                                $display("FAIL byte dut%0d idx%0d: got %02h, want %02h", k, b, sh[k], eby);
                            end
                        end
                        if (ncap[k] == k * 8 + 48) done_exp[k] = 1;
                    end
                end
                if (!active[k] && start_v[k]) begin
                    vectors++;
                    if (exp_q[k].size() == 0) begin
                        miscompares++;
                        $display("FAIL accept dut%0d: start accepted with no frame queued, want none", k);
                    end else begin
                        cur[k] = exp_q[k].pop_front();
                        acc[k] = 1;
                    end
                end
            end
        end
    end

    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [47:0] f);
        cmd_index = c;
        argument  = a;
        for (int k = 0; k < 3; k++) exp_q[k].push_back(f);
        start_v = 3'b111;
        @(posedge clk); #1 start_v = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 5000 && (active[0] || active[1] || active[2] || acc[0] || acc[1] || acc[2] ||
               exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0)) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 5000) begin
            miscompares++;
            $display("FAIL timeout: frames still pending after %0d cycles, want all complete", n);
        end
    endtask

    task automatic run(input logic [5:0] c, input logic [31:0] a, input logic [47:0] f);
        issue(c, a, f);
        wait_idle();
    endtask

    initial begin
        int cnt[3];
        int n;
        reset = 1'b1; start_v = '0; cmd_index = '0; argument = '0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        run(6'd0, 32'h0, 48'h40_0000_0000_95);
        run(6'd8, 32'h1AA, 48'h48_0000_01AA_87);
        // second start mid-frame with different fields must be ignored
        issue(6'd0, 32'h0, 48'h40_0000_0000_95);
        repeat (40) @(posedge clk);
        #1 cmd_index = 6'd17; argument = $urandom; start_v = 3'b111;
        @(posedge clk); #1 start_v = 3'b000;
        wait_idle();
        // reset after 20 frame bits of the PRE_BYTES=1 instance
        issue(6'd0, 32'h0, 48'h40_0000_0000_95);
        n = 0;
        while (n < 5000 && ncap[1] < 28) begin @(posedge clk); #1; n++; end
        if (n >= 5000) begin
            miscompares++;
            $display("FAIL timeout: reached %0d bits before reset, want 28", ncap[1]);
        end
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        run(6'd0, 32'h0, 48'h40_0000_0000_95);
        // start held high: two back-to-back frames per instance
        cmd_index = 6'd0; argument = 32'h0;
        for (int k = 0; k < 3; k++) begin
            exp_q[k].push_back(48'h40_0000_0000_95);
            exp_q[k].push_back(48'h40_0000_0000_95);
            cnt[k] = 0;
        end
        start_v = 3'b111;
        n = 0;
        while (n < 10000 && start_v != 3'b000) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                if (done_v[k]) cnt[k]++;
                if (cnt[k] >= 2) start_v[k] = 1'b0;
            end
            n++;
        end
        if (n >= 10000) begin
            miscompares++;
            $display("FAIL timeout: back-to-back done counts %0d/%0d/%0d, want 2 each", cnt[0], cnt[1], cnt[2]);
            start_v = 3'b000;
        end
        wait_idle();
        for (int i = 0; i < 6; i++) begin
            logic [5:0]  c;
            logic [31:0] a;
            c = 6'($urandom_range(0, 63));
            a = $urandom;
            run(c, a, frame_of(c, a));
        end
        repeat (10) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
